// File: rtl/mem_port_responder.sv
// Memory-side responder for one mem_handle port. Requests are serviced
// against a synchronous single-port RAM. Posted writes go into a small
// circular buffer that drains to the RAM whenever the port is idle. Reads
// are forwarded from that buffer when they hit it. Through requests first
// drain the buffer completely, so they are ordered against the RAM.
//
// Every output is a register. Each one is loaded from next-state values,
// so a RAM access becomes visible in the same cycle as the state that owns it.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a request; pops one buffer entry if none arrives
// S_DRAIN   | through request pending; one buffer entry is written per cycle
// S_RAM_WR  | through-write data on the RAM port
// S_RD_ADDR | read address on the RAM port
// S_RD_DATA | RAM read data valid, captured into data_load at the edge
// S_RESP    | done pulse; a new request may be accepted here
module mem_port_responder #(
  parameter int ADDR_SIZE = 23,
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 1024,
  parameter int BUF_DEPTH = 8,   // must be a power of two (pointers wrap naturally)
  localparam int RA = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [ADDR_SIZE-1:0] region_begin,
  input  logic [ADDR_SIZE-1:0] region_end,
  input  logic [ADDR_SIZE-1:0] ptr,
  input  logic                 w_en,
  input  logic                 r_en,
  input  logic                 write_through,
  input  logic                 read_through,
  input  logic [DATA_SIZE-1:0] data_store,
  output logic                 avail,
  output logic                 done,
  output logic                 fault,
  output logic [DATA_SIZE-1:0] data_load,
  output logic [RA-1:0]        ram_addr,
  output logic [DATA_SIZE-1:0] ram_wdata,
  output logic                 ram_we,
  input  logic [DATA_SIZE-1:0] ram_rdata
);

  localparam int BI = $clog2(BUF_DEPTH);
  localparam logic [BI:0]        BUF_FULL  = (BI+1)'(BUF_DEPTH);
  localparam logic [ADDR_SIZE:0] DEPTH_LIM = (ADDR_SIZE+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_RAM_WR, S_RD_ADDR, S_RD_DATA, S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [RA-1:0]        buf_addr [BUF_DEPTH];
  logic [DATA_SIZE-1:0] buf_data [BUF_DEPTH];
  logic [BI-1:0]        head, tail;
  logic [BI:0]          count, count_nxt;

  logic [RA-1:0]        req_addr;
  logic [DATA_SIZE-1:0] req_data;
  logic                 req_write;

  logic                 accept, bad_req, hit, capture, push, pop;
  logic [RA-1:0]        ptr_ram;
  logic [DATA_SIZE-1:0] hit_data;
  logic [BI-1:0]        slot;

  logic                 avail_nxt, done_nxt, fault_nxt, ram_we_nxt;
  logic [DATA_SIZE-1:0] data_load_nxt, ram_wdata_nxt;
  logic [RA-1:0]        ram_addr_nxt;

  // avail is registered high only in S_IDLE/S_RESP, so it alone qualifies a strobe
  assign accept  = avail & (w_en | r_en);
  assign ptr_ram = ptr[RA-1:0];
  assign bad_req = (w_en & r_en) | (ptr < region_begin) | (ptr > region_end)
                 | ({1'b0, ptr} >= DEPTH_LIM);

  // Buffer search, oldest to newest, so the newest matching entry is kept
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    slot     = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      slot = head + BI'(i);
      if (((BI+1)'(i) < count) && (buf_addr[slot] == ptr_ram)) begin
        hit      = 1'b1;
        hit_data = buf_data[slot];
      end
    end
  end

  // Next-state logic and next values of the registered outputs
  always_comb begin
    state_nxt     = state;
    capture       = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    fault_nxt     = 1'b0;
    data_load_nxt = data_load;
    ram_we_nxt    = 1'b0;
    ram_addr_nxt  = ram_addr;
    ram_wdata_nxt = ram_wdata;
    case (state)
      S_IDLE, S_RESP: begin
        if (accept) begin
          capture = 1'b1;
          if (bad_req) begin
            state_nxt = S_RESP;
            fault_nxt = 1'b1;
          end else if (w_en && !write_through) begin
            state_nxt = S_RESP;
            push      = 1'b1;
          end else if (w_en) begin
            if (count != '0) begin
              state_nxt = S_DRAIN;
              pop       = 1'b1;
            end else begin
              state_nxt     = S_RAM_WR;
              ram_we_nxt    = 1'b1;
              ram_addr_nxt  = ptr_ram;
              ram_wdata_nxt = data_store;
            end
          end else if (!read_through && hit) begin
            state_nxt     = S_RESP;
            data_load_nxt = hit_data;
          end else if (read_through && (count != '0)) begin
            state_nxt = S_DRAIN;
            pop       = 1'b1;
          end else begin
            state_nxt    = S_RD_ADDR;
            ram_addr_nxt = ptr_ram;
          end
        end else begin
          state_nxt = S_IDLE;
          // RESP never drains; only a quiet IDLE cycle does
          pop = (state == S_IDLE) && (count != '0);
        end
      end
      S_DRAIN: begin
        if (count != '0) begin
          pop = 1'b1;
        end else if (req_write) begin
          state_nxt     = S_RAM_WR;
          ram_we_nxt    = 1'b1;
          ram_addr_nxt  = req_addr;
          ram_wdata_nxt = req_data;
        end else begin
          state_nxt    = S_RD_ADDR;
          ram_addr_nxt = req_addr;
        end
      end
      S_RAM_WR:  state_nxt = S_RESP;
      S_RD_ADDR: state_nxt = S_RD_DATA;
      S_RD_DATA: begin
        state_nxt     = S_RESP;
        data_load_nxt = ram_rdata;
      end
      default:   state_nxt = S_IDLE;
    endcase
    if (pop) begin
      ram_we_nxt    = 1'b1;
      ram_addr_nxt  = buf_addr[head];
      ram_wdata_nxt = buf_data[head];
    end
  end

  // Occupancy update; push and pop are mutually exclusive by construction
  always_comb begin
    count_nxt = count;
    if (push)     count_nxt = count + (BI+1)'(1);
    else if (pop) count_nxt = count - (BI+1)'(1);
  end

  assign done_nxt  = (state_nxt == S_RESP);
  assign avail_nxt = ((state_nxt == S_IDLE) || (state_nxt == S_RESP)) && (count_nxt < BUF_FULL);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Buffer pointers, captured request and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      req_addr  <= '0;
      req_data  <= '0;
      req_write <= 1'b0;
      avail     <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      data_load <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      if (push) tail <= tail + BI'(1);
      if (pop)  head <= head + BI'(1);
      count <= count_nxt;
      if (capture) begin
        req_addr  <= ptr_ram;
        req_data  <= data_store;
        req_write <= w_en;
      end
      avail     <= avail_nxt;
      done      <= done_nxt;
      fault     <= fault_nxt;
      data_load <= data_load_nxt;
      ram_we    <= ram_we_nxt;
      ram_addr  <= ram_addr_nxt;
      ram_wdata <= ram_wdata_nxt;
    end
  end

  // Buffer storage; contents are meaningful only between head and tail
  always_ff @(posedge clock) begin
    if (push) begin
      buf_addr[tail] <= ptr_ram;
      buf_data[tail] <= data_store;
    end
  end

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed and randomized bench for mem_port_responder. The reference model
// is a transaction-level view. It holds the logical memory contents, which are
// the last value written per address in program order, and a FIFO of posted
// writes that are not yet on the RAM. Expected latencies come from that FIFO's
// occupancy at acceptance.
module tb_mem_port_responder;
  localparam int AW = 23, DW = 32, DEPTH = 1024;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [AW-1:0] region_begin, region_end, ptr;
  logic          w_en, r_en, write_through, read_through;
  logic [DW-1:0] data_store, data_load, ram_wdata, ram_rdata;
  logic          avail, done, fault, ram_we;
  logic [9:0]    ram_addr;

  logic [DW-1:0] mem [DEPTH] = '{default: '0};
  logic [DW-1:0] ref_mem [DEPTH];

  typedef struct packed { logic [9:0] a; logic [31:0] d; } ent_t;
  ent_t q[$];
  logic        tw_pend;
  logic [9:0]  tw_addr;
  logic [31:0] tw_data;
  logic [31:0] exp_load;
  int n_vec, n_err, we_seen, last_lat, last_waits;

  mem_port_responder dut (
    .clock(clock), .reset_n(reset_n),
    .region_begin(region_begin), .region_end(region_end), .ptr(ptr),
    .w_en(w_en), .r_en(r_en), .write_through(write_through), .read_through(read_through),
    .data_store(data_store), .avail(avail), .done(done), .fault(fault),
    .data_load(data_load), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  // synchronous single-port RAM
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // advance one cycle and check any RAM write against the model
  task automatic tick();
    @(posedge clock);
    #1;
    if (ram_we) begin
      we_seen++;
      if (q.size() > 0) begin
        check("drain_addr", ram_addr, q[0].a);
        check("drain_data", ram_wdata, q[0].d);
        void'(q.pop_front());
      end else if (tw_pend) begin
        check("thru_wr_addr", ram_addr, tw_addr);
        check("thru_wr_data", ram_wdata, tw_data);
        tw_pend = 1'b0;
      end else begin
        check("spurious_we", ram_we, 1'b0);
      end
    end
  endtask

  task automatic do_req(input logic we, input logic re, input logic wt, input logic rt,
                        input logic [AW-1:0] p, input logic [31:0] d);
    int   n, lat, waits, exp_lat;
    logic flt, hit;
    ent_t e;
    ptr = p; w_en = we; r_en = re; write_through = wt; read_through = rt; data_store = d;
    waits = 0;
    while (!avail && waits < 60) begin
      tick();
      waits++;
    end
    last_waits = waits;
    check("avail_wait", avail, 1'b1);
    flt = (we && re) || (p < region_begin) || (p > region_end) || (p >= AW'(DEPTH));
    n   = q.size();
    hit = 1'b0;
    foreach (q[i]) if (q[i].a == p[9:0]) hit = 1'b1;
    if (flt) exp_lat = 1;
    else if (we && !wt) begin
      exp_lat = 1;
      e.a = p[9:0];
      e.d = d;
      q.push_back(e);
      ref_mem[p[9:0]] = d;
    end else if (we) begin
      exp_lat = n + 2;
      tw_pend = 1'b1;
      tw_addr = p[9:0];
      tw_data = d;
      ref_mem[p[9:0]] = d;
    end else if (!rt) exp_lat = hit ? 1 : 3;
    else exp_lat = n + 3;
    if (!flt && re) exp_load = ref_mem[p[9:0]];
    tick();
    w_en = 1'b0; r_en = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      tick();
      lat++;
    end
    last_lat = lat;
    check("done_latency", lat, exp_lat);
    check("fault_flag", fault, flt);
    check("data_load", data_load, exp_load);
  endtask

  initial begin
    int          w0, op, gap, k;
    logic [31:0] old_v [4];
    logic [31:0] new_v [4];
    logic [AW-1:0] rp;
    n_vec = 0; n_err = 0; we_seen = 0; tw_pend = 1'b0; exp_load = '0;
    foreach (ref_mem[i]) ref_mem[i] = '0;
    region_begin = '0; region_end = AW'(DEPTH - 1);
    ptr = 7; data_store = 32'h1234; write_through = 0; read_through = 0;
    w_en = 1'b1; r_en = 1'b1;
    reset_n = 1'b0;

    // reset held with strobes active
    repeat (3) tick();
    check("rst_avail", avail, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_data_load", data_load, 32'h0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_addr", ram_addr, 10'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    w_en = 1'b0; r_en = 1'b0;
    reset_n = 1'b1;
    tick();
    check("rst_release_avail", avail, 1'b1);

    // posted write then forwarded read in the done cycle
    w0 = we_seen;
    do_req(1, 0, 0, 0, 5, 32'hDEADBEEF);
    do_req(0, 1, 0, 0, 5, 0);
    check("fwd_read_lat", last_lat, 1);
    repeat (4) tick();
    check("post_drain_count", we_seen - w0, 1);

    // fill the buffer back to back, ninth strobe pending
    w0 = we_seen;
    for (int i = 0; i < 8; i++) do_req(1, 0, 0, 0, AW'(i), $urandom);
    check("fill_no_we", we_seen - w0, 0);
    check("fill_avail_low", avail, 1'b0);
    do_req(1, 0, 0, 0, 8, 32'h99);
    check("fill_ninth_wait", last_waits, 2);
    repeat (14) tick();
    check("fill_drained", we_seen - w0, 9);

    // forwarding: newest entry wins; through-read drains first
    do_req(1, 0, 0, 0, 10, 32'h1);
    do_req(1, 0, 0, 0, 10, 32'h2);
    do_req(1, 0, 0, 0, 11, 32'h3);
    w0 = we_seen;
    do_req(0, 1, 0, 0, 10, 0);
    check("fwd_hit_data", data_load, 32'h2);
    do_req(0, 1, 0, 1, 10, 0);
    check("fwd_thru_lat", last_lat, 6);
    check("fwd_thru_we", we_seen - w0, 3);

    // through-write behind two posted entries
    do_req(1, 0, 0, 0, 300, 32'hA);
    do_req(1, 0, 0, 0, 301, 32'hB);
    do_req(1, 0, 1, 0, 302, 32'hC);
    check("thru_wr_lat", last_lat, 4);
    do_req(0, 1, 0, 0, 302, 0);

    // faults
    repeat (4) tick();
    w0 = we_seen;
    region_end = 500;
    do_req(1, 0, 0, 0, 501, 32'h55);
    region_begin = 20;
    do_req(0, 1, 0, 0, 19, 0);
    region_begin = 0; region_end = 2000;
    do_req(1, 0, 0, 0, 1024, 32'h66);
    do_req(0, 1, 0, 0, 1024, 0);
    region_end = AW'(DEPTH - 1);
    do_req(1, 1, 0, 0, 3, 32'h77);
    check("fault_no_we", we_seen - w0, 0);

    // reset during the second drain cycle
    for (int i = 0; i < 4; i++) begin
      old_v[i] = ref_mem[100 + i];
      new_v[i] = $urandom | 32'h1;
    end
    for (int i = 0; i < 4; i++) do_req(1, 0, 0, 0, AW'(100 + i), new_v[i]);
    w0 = we_seen;
    k = 0;
    while ((we_seen - w0) < 2 && k < 20) begin
      tick();
      k++;
    end
    check("mid_drain_reached", we_seen - w0, 2);
    reset_n = 1'b0;
    q.delete();
    tw_pend = 1'b0;
    exp_load = '0;
    for (int i = 1; i < 4; i++) ref_mem[100 + i] = old_v[i];
    tick();
    check("mid_rst_ram_we", ram_we, 1'b0);
    check("mid_rst_avail", avail, 1'b0);
    reset_n = 1'b1;
    tick();
    check("mid_rst_release", avail, 1'b1);
    w0 = we_seen;
    repeat (5) tick();
    check("mid_rst_empty", we_seen - w0, 0);
    for (int i = 0; i < 4; i++) do_req(0, 1, 0, 1, AW'(100 + i), 0);
    check("mid_rst_last", data_load, old_v[3]);

    // randomized mix against the transaction model
    for (int it = 0; it < 150; it++) begin
      op  = $urandom_range(0, 9);
      gap = $urandom_range(0, 2);
      rp  = AW'(200 + $urandom_range(0, 15));
      repeat (gap) tick();
      case (op)
        0, 1, 2, 3: do_req(1, 0, 0, 0, rp, $urandom);
        4, 5:       do_req(0, 1, 0, 0, rp, 0);
        6:          do_req(0, 1, 0, 1, rp, 0);
        7:          do_req(1, 0, 1, 0, rp, $urandom);
        8:          do_req(0, 1, 0, 0, AW'($urandom_range(1024, 1100)), 0);
        default:    do_req(1, 0, 0, 0, AW'($urandom_range(0, 1023)), $urandom);
      endcase
    end
    repeat (20) tick();
    check("final_model_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
